seq_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 9 +
 rtl/mult_step.sv | 41 ++++
 rtl/seq_multiplier.sv | 105 ++++++++++
 tb/tb_seq_multiplier.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and bus function codes for the sequential multiplier.
package mult_pkg;
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] FN_LDM = 2'b00;
    localparam logic [1:0] FN_LDQ = 2'b01;
    localparam logic [1:0] FN_RDL = 2'b10;
    localparam logic [1:0] FN_RDH = 2'b11;
endpackage

// File: rtl/mult_step.sv
// One multiply iteration: unsigned shift-add (mode=0) or radix-2 Booth (mode=1).
module mult_step #(
    parameter int n = 8
) (
    input  logic         mode,
    input  logic [n:0]   a,
    input  logic [n-1:0] q,
    input  logic         q_1,
    input  logic         c,
    input  logic [n-1:0] mcap,
    output logic [n:0]   a_nxt,
    output logic [n-1:0] q_nxt,
    output logic         q_1_nxt,
    output logic         c_nxt
);
    logic [n:0] m_ext;
    logic [n:0] sum;

    always_comb begin
        m_ext   = {mcap[n-1], mcap};
        sum     = a;
        a_nxt   = a;
        q_nxt   = q;
        q_1_nxt = q[0];
        c_nxt   = 1'b0;
        if (mode) begin
            // A carries an extra sign bit so -2^(n-1) * -2^(n-1) stays representable
            case ({q[0], q_1})
                2'b01:   sum = a + m_ext;
                2'b10:   sum = a - m_ext;
                default: sum = a;
            endcase
            a_nxt = {sum[n], sum[n:1]};
        end else begin
            // sum[n] is the carry C; the shift drops it into A's top data bit
            sum   = q[0] ? ({1'b0, a[n-1:0]} + {1'b0, mcap}) : {c, a[n-1:0]};
            a_nxt = {1'b0, sum[n:1]};
        end
        q_nxt = {sum[0], q[n-1:1]};
    end
endmodule

// File: rtl/seq_multiplier.sv
// Sequential n x n multiplier with register bus and start/ready/done handshake.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [1:0]   func,
    input  logic         wr,
    input  logic [n-1:0] data_in,
    input  logic         rd,
    output logic [n-1:0] data_out,
    output logic         data_oe,
    input  logic         sgn,
    input  logic         start,
    output logic         ready,
    output logic         done
);
    localparam int CW = $clog2(n) + 1;

    state_t         state, state_nxt;
    logic [n-1:0]   m_reg, q_reg, mcap, aq, aq_nxt;
    logic [n:0]     a, a_nxt;
    logic           q_1, q_1_nxt, c, c_nxt, mode;
    logic [CW-1:0]  cnt;
    logic [2*n-1:0] p;
    logic           last;

    assign last = (cnt == CW'(1));

    mult_step #(.n(n)) u_step (
        .mode    (mode),
        .a       (a),
        .q       (aq),
        .q_1     (q_1),
        .c       (c),
        .mcap    (mcap),
        .a_nxt   (a_nxt),
        .q_nxt   (aq_nxt),
        .q_1_nxt (q_1_nxt),
        .c_nxt   (c_nxt)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_reg <= '0;
            q_reg <= '0;
            mcap  <= '0;
            a     <= '0;
            aq    <= '0;
            q_1   <= 1'b0;
            c     <= 1'b0;
            mode  <= 1'b0;
            cnt   <= '0;
            p     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (wr && func == FN_LDM) m_reg <= data_in;
                if (wr && func == FN_LDQ) q_reg <= data_in;
                // operands come from the pre-edge registers, so a same-cycle write is not seen
                if (start) begin
                    mode <= sgn;
                    a    <= '0;
                    aq   <= q_reg;
                    q_1  <= 1'b0;
                    c    <= 1'b0;
                    mcap <= m_reg;
                    cnt  <= CW'(n);
                end
            end else begin
                a   <= a_nxt;
                aq  <= aq_nxt;
                q_1 <= q_1_nxt;
                c   <= c_nxt;
                cnt <= cnt - CW'(1);
                if (last) begin
                    p    <= {a_nxt[n-1:0], aq_nxt};
                    done <= 1'b1;
                end
            end
        end
    end

    assign ready    = (state == IDLE);
    assign data_oe  = rd & func[1];
    assign data_out = !data_oe        ? '0 :
                      (func == FN_RDH) ? p[2*n-1:n] : p[n-1:0];
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized checks of seq_multiplier at n=8, plus n=4 / n=16 sweeps.
module tb_seq_multiplier;
    import mult_pkg::*;

    logic osc_clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 osc_clk = ~osc_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // n = 8 instance
    logic [1:0] func8 = '0;
    logic       wr8 = 0, rd8 = 0, sgn8 = 0, start8 = 0;
    logic [7:0] din8 = '0, dout8;
    logic       oe8, ready8, done8;
    seq_multiplier #(.n(8)) u8 (
        .clk(osc_clk), .n_reset(n_reset), .func(func8), .wr(wr8), .data_in(din8),
        .rd(rd8), .data_out(dout8), .data_oe(oe8), .sgn(sgn8), .start(start8),
        .ready(ready8), .done(done8));

    // n = 4 instance
    logic [1:0] func4 = '0;
    logic       wr4 = 0, rd4 = 0, sgn4 = 0, start4 = 0;
    logic [3:0] din4 = '0, dout4;
    logic       oe4, ready4, done4;
    seq_multiplier #(.n(4)) u4 (
        .clk(osc_clk), .n_reset(n_reset), .func(func4), .wr(wr4), .data_in(din4),
        .rd(rd4), .data_out(dout4), .data_oe(oe4), .sgn(sgn4), .start(start4),
        .ready(ready4), .done(done4));

    // n = 16 instance
    logic [1:0]  func16 = '0;
    logic        wr16 = 0, rd16 = 0, sgn16 = 0, start16 = 0;
    logic [15:0] din16 = '0, dout16;
    logic        oe16, ready16, done16;
    seq_multiplier #(.n(16)) u16 (
        .clk(osc_clk), .n_reset(n_reset), .func(func16), .wr(wr16), .data_in(din16),
        .rd(rd16), .data_out(dout16), .data_oe(oe16), .sgn(sgn16), .start(start16),
        .ready(ready16), .done(done16));

    task automatic wr_reg8(input logic [1:0] fn, input logic [7:0] d);
        @(negedge osc_clk);
        func8 = fn; din8 = d; wr8 = 1'b1;
        @(negedge osc_clk);
        wr8 = 1'b0;
    endtask

    task automatic read8(output logic [15:0] p);
        rd8 = 1'b1; func8 = FN_RDL; #1 p[7:0] = dout8;
        func8 = FN_RDH;             #1 p[15:8] = dout8;
        rd8 = 1'b0;
    endtask

    // Pulse start, count cycles to done and cycles with ready low, then check the done width.
    task automatic run8(input logic s, output int cyc, output int busy, output logic pulse_ok);
        @(negedge osc_clk);
        sgn8 = s; start8 = 1'b1;
        @(negedge osc_clk);
        start8 = 1'b0;
        cyc = 0; busy = 0;
        while (!done8 && cyc < 40) begin
            if (!ready8) busy++;
            @(negedge osc_clk);
            cyc++;
        end
        pulse_ok = ready8;
        @(negedge osc_clk);
        pulse_ok = pulse_ok & !done8 & ready8;
    endtask

    task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic s,
                       output logic [15:0] p, output int cyc, output int busy, output logic pulse_ok);
        wr_reg8(FN_LDM, m);
        wr_reg8(FN_LDQ, q);
        run8(s, cyc, busy, pulse_ok);
        read8(p);
    endtask

    task automatic test_reset;
        logic [15:0] p;
        #2;
        n_checks++; if (ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready8); end
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done8); end
        read8(p);
        n_checks++; if (p !== 16'h0000) begin n_fail++; $display("FAIL reset_p: got %h want 0000", p); end
        rd8 = 1'b1; func8 = FN_LDQ; #1;
        n_checks++; if (oe8 !== 1'b0 || dout8 !== 8'h00) begin n_fail++; $display("FAIL oe_write_func: oe=%b dout=%h want 0/00", oe8, dout8); end
        rd8 = 1'b0;
        @(negedge osc_clk);
        n_reset = 1'b1;
    endtask

    task automatic test_unsigned;
        logic [7:0]  mv [3] = '{8'd200, 8'd255, 8'h00};
        logic [7:0]  qv [3] = '{8'd150, 8'd255, 8'hAB};
        logic [15:0] ev [3] = '{16'h7530, 16'hFE01, 16'h0000};
        logic [15:0] p;
        int cyc, busy;
        logic pok;
        for (int i = 0; i < 3; i++) begin
            op8(mv[i], qv[i], 1'b0, p, cyc, busy, pok);
            n_checks++; if (p !== ev[i]) begin n_fail++; $display("FAIL unsigned_p[%0d]: got %h want %h", i, p, ev[i]); end
            n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL unsigned_latency[%0d]: got %0d want 8", i, cyc); end
            n_checks++; if (busy !== 8) begin n_fail++; $display("FAIL unsigned_busy[%0d]: got %0d want 8", i, busy); end
            n_checks++; if (pok !== 1'b1) begin n_fail++; $display("FAIL unsigned_done_pulse[%0d]: got %b want 1", i, pok); end
        end
        // 200*150: low half 0x30, high half 0x75 were read above; check data_oe explicitly
        rd8 = 1'b1; func8 = FN_RDH; #1;
        n_checks++; if (oe8 !== 1'b1) begin n_fail++; $display("FAIL oe_read: got %b want 1", oe8); end
        rd8 = 1'b0; #1;
        n_checks++; if (dout8 !== 8'h00) begin n_fail++; $display("FAIL dout_idle: got %h want 00", dout8); end
    endtask

    task automatic test_signed;
        logic [7:0]  mv [3] = '{8'hFD, 8'h80, 8'h80};
        logic [7:0]  qv [3] = '{8'h05, 8'h80, 8'h7F};
        logic [15:0] ev [3] = '{16'hFFF1, 16'h4000, 16'hC080};
        logic [15:0] p;
        int cyc, busy;
        logic pok;
        for (int i = 0; i < 3; i++) begin
            op8(mv[i], qv[i], 1'b1, p, cyc, busy, pok);
            n_checks++; if (p !== ev[i]) begin n_fail++; $display("FAIL signed_p[%0d]: got %h want %h", i, p, ev[i]); end
            n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL signed_latency[%0d]: got %0d want 8", i, cyc); end
        end
    endtask

    // Busy rules: start and wr during RUN are dropped; the old P stays readable.
    task automatic test_back_to_back;
        logic [15:0] p, pmid;
        int cyc, busy;
        logic pok;
        wr_reg8(FN_LDM, 8'd7);
        wr_reg8(FN_LDQ, 8'd9);
        @(negedge osc_clk);
        sgn8 = 1'b0; start8 = 1'b1;
        @(negedge osc_clk);
        start8 = 1'b0;
        cyc = 0; busy = 0; pmid = '0;
        while (!done8 && cyc < 40) begin
            if (!ready8) busy++;
            if (cyc == 3) begin start8 = 1'b1; wr8 = 1'b1; func8 = FN_LDM; din8 = 8'h11; end
            if (cyc == 5) read8(pmid);
            @(negedge osc_clk);
            cyc++;
            start8 = 1'b0; wr8 = 1'b0;
        end
        read8(p);
        n_checks++; if (pmid !== 16'hC080) begin n_fail++; $display("FAIL old_p_during_run: got %h want c080", pmid); end
        n_checks++; if (p !== 16'h003F) begin n_fail++; $display("FAIL busy_p: got %h want 003f", p); end
        n_checks++; if (cyc !== 8 || busy !== 8) begin n_fail++; $display("FAIL busy_latency: got %0d/%0d want 8/8", cyc, busy); end
        repeat (3) @(negedge osc_clk);
        n_checks++; if (ready8 !== 1'b1 || done8 !== 1'b0) begin n_fail++; $display("FAIL no_queued_start: ready=%b done=%b want 1/0", ready8, done8); end
        wr_reg8(FN_LDQ, 8'd1);
        run8(1'b0, cyc, busy, pok);
        read8(p);
        n_checks++; if (p !== 16'h0007) begin n_fail++; $display("FAIL m_kept: got %h want 0007", p); end
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] p;
        int cyc, busy;
        logic pok;
        op8(8'h12, 8'h34, 1'b0, p, cyc, busy, pok);
        n_checks++; if (p !== 16'h03A8) begin n_fail++; $display("FAIL pre_reset_p: got %h want 03a8", p); end
        @(negedge osc_clk);
        start8 = 1'b1;
        @(negedge osc_clk);
        start8 = 1'b0;
        repeat (3) @(negedge osc_clk);
        #2 n_reset = 1'b0;
        #1;
        n_checks++; if (ready8 !== 1'b1 || done8 !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_ctl: ready=%b done=%b want 1/0", ready8, done8); end
        read8(p);
        n_checks++; if (p !== 16'h0000) begin n_fail++; $display("FAIL midrun_reset_p: got %h want 0000", p); end
        @(negedge osc_clk);
        n_reset = 1'b1;
        wr_reg8(FN_LDQ, 8'd4);
        run8(1'b0, cyc, busy, pok);
        read8(p);
        n_checks++; if (p !== 16'h0000) begin n_fail++; $display("FAIL m_cleared: got %h want 0000", p); end
        wr_reg8(FN_LDM, 8'd3);
        run8(1'b0, cyc, busy, pok);
        read8(p);
        n_checks++; if (p !== 16'h000C) begin n_fail++; $display("FAIL post_reset_p: got %h want 000c", p); end
    endtask

    task automatic test_sweep4;
        logic [3:0] m, q;
        logic [7:0] p;
        logic s, pok;
        longint e;
        int cyc;
        for (int i = 0; i < 1000; i++) begin
            m = 4'($urandom); q = 4'($urandom); s = 1'($urandom_range(0, 1));
            @(negedge osc_clk); func4 = FN_LDM; din4 = m; wr4 = 1'b1;
            @(negedge osc_clk); func4 = FN_LDQ; din4 = q;
            @(negedge osc_clk); wr4 = 1'b0; sgn4 = s; start4 = 1'b1;
            @(negedge osc_clk); start4 = 1'b0;
            cyc = 0;
            while (!done4 && cyc < 40) begin @(negedge osc_clk); cyc++; end
            @(negedge osc_clk);
            pok = !done4 && ready4;
            rd4 = 1'b1; func4 = FN_RDL; #1 p[3:0] = dout4;
            func4 = FN_RDH;             #1 p[7:4] = dout4;
            rd4 = 1'b0;
            e = s ? longint'($signed(m)) * longint'($signed(q)) : longint'(m) * longint'(q);
            n_checks++; if (p !== e[7:0]) begin n_fail++; $display("FAIL sweep4_p: m=%h q=%h s=%b got %h want %h", m, q, s, p, e[7:0]); end
            n_checks++; if (cyc !== 4 || !pok) begin n_fail++; $display("FAIL sweep4_timing: cyc=%0d pulse=%b want 4/1", cyc, pok); end
        end
    endtask

    task automatic test_sweep16;
        logic [15:0] m, q;
        logic [31:0] p;
        logic s, pok;
        longint e;
        int cyc;
        for (int i = 0; i < 1000; i++) begin
            m = 16'($urandom); q = 16'($urandom); s = 1'($urandom_range(0, 1));
            if (i == 0) begin m = 16'h8000; q = 16'h8000; s = 1'b1; end
            if (i == 1) begin m = 16'hFFFF; q = 16'hFFFF; s = 1'b0; end
            @(negedge osc_clk); func16 = FN_LDM; din16 = m; wr16 = 1'b1;
            @(negedge osc_clk); func16 = FN_LDQ; din16 = q;
            @(negedge osc_clk); wr16 = 1'b0; sgn16 = s; start16 = 1'b1;
            @(negedge osc_clk); start16 = 1'b0;
            cyc = 0;
            while (!done16 && cyc < 60) begin @(negedge osc_clk); cyc++; end
            @(negedge osc_clk);
            pok = !done16 && ready16;
            rd16 = 1'b1; func16 = FN_RDL; #1 p[15:0] = dout16;
            func16 = FN_RDH;              #1 p[31:16] = dout16;
            rd16 = 1'b0;
            e = s ? longint'($signed(m)) * longint'($signed(q)) : longint'(m) * longint'(q);
            n_checks++; if (p !== e[31:0]) begin n_fail++; $display("FAIL sweep16_p: m=%h q=%h s=%b got %h want %h", m, q, s, p, e[31:0]); end
            n_checks++; if (cyc !== 16 || !pok) begin n_fail++; $display("FAIL sweep16_timing: cyc=%0d pulse=%b want 16/1", cyc, pok); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep4();
        test_sweep16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
